// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: latches hall and cabin calls and hands the motion
// controller one target floor at a time, sweeping in a committed direction.
module elevator_call_scheduler #(
  parameter int FLOOR_COUNT = 10,
  parameter int FLOOR_W     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [FLOOR_COUNT-1:0] hall_up_req,
  input  logic [FLOOR_COUNT-1:0] hall_dn_req,
  input  logic [FLOOR_COUNT-1:0] cabin_req,
  input  logic [FLOOR_W-1:0]     cur_floor,
  input  logic                   arrived,
  input  logic                   target_ready,
  output logic                   target_valid,
  output logic [FLOOR_W-1:0]     target_floor,
  output logic                   dir_up,
  output logic                   busy,
  output logic [FLOOR_COUNT-1:0] pending_up,
  output logic [FLOOR_COUNT-1:0] pending_dn,
  output logic [FLOOR_COUNT-1:0] pending_cab
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_MOVING = 3'd3,
    ST_SERVE  = 3'd4
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [FLOOR_COUNT-1:0] pending_up_r, pending_dn_r, pending_cab_r;
  logic                   target_valid_r, dir_up_r, busy_r;
  logic [FLOOR_W-1:0]     target_floor_r;

  logic [FLOOR_COUNT-1:0] above_s, below_s, at_s, tgt_above_s, tgt_below_s;
  logic [FLOOR_COUNT-1:0] any_s, qual_up_s, qual_dn_s;
  logic [FLOOR_COUNT-1:0] near_up_v_s, far_up_v_s, near_dn_v_s, far_dn_v_s;
  logic [FLOOR_COUNT-1:0] rt_up_v_s, rt_dn_v_s;
  logic [FLOOR_COUNT-1:0] clr_up_s, clr_dn_s, clr_cab_s;
  logic                   cur_ok_s, here_s, beyond_up_s, beyond_dn_s, beyond_dir_s;
  logic                   cand_s, cand_rev_s, retgt_s, serve_s;
  logic [FLOOR_W-1:0]     cand_idx_s, retgt_idx_s;

  function automatic logic [FLOOR_W-1:0] low_idx(input logic [FLOOR_COUNT-1:0] v);
    logic [FLOOR_W-1:0] r;
    r = {FLOOR_W{1'b0}};
    for (int i = FLOOR_COUNT - 1; i >= 0; i--) r = v[i] ? FLOOR_W'(i) : r;
    return r;
  endfunction

  function automatic logic [FLOOR_W-1:0] high_idx(input logic [FLOOR_COUNT-1:0] v);
    logic [FLOOR_W-1:0] r;
    r = {FLOOR_W{1'b0}};
    for (int i = 0; i < FLOOR_COUNT; i++) r = v[i] ? FLOOR_W'(i) : r;
    return r;
  endfunction

  // Floor position masks relative to the cabin and to the current target.
  always_comb begin
    above_s     = {FLOOR_COUNT{1'b0}};
    below_s     = {FLOOR_COUNT{1'b0}};
    at_s        = {FLOOR_COUNT{1'b0}};
    tgt_above_s = {FLOOR_COUNT{1'b0}};
    tgt_below_s = {FLOOR_COUNT{1'b0}};
    for (int i = 0; i < FLOOR_COUNT; i++) begin
      above_s[i]     = (FLOOR_W'(i) > cur_floor);
      below_s[i]     = (FLOOR_W'(i) < cur_floor);
      at_s[i]        = (FLOOR_W'(i) == cur_floor);
      tgt_above_s[i] = (FLOOR_W'(i) > target_floor_r);
      tgt_below_s[i] = (FLOOR_W'(i) < target_floor_r);
    end
  end

  assign any_s       = pending_up_r | pending_dn_r | pending_cab_r;
  assign qual_up_s   = pending_cab_r | pending_up_r;
  assign qual_dn_s   = pending_cab_r | pending_dn_r;
  assign cur_ok_s    = (int'(cur_floor) < FLOOR_COUNT);
  assign near_up_v_s = above_s & qual_up_s;
  assign far_up_v_s  = above_s & pending_dn_r;
  assign near_dn_v_s = below_s & qual_dn_s;
  assign far_dn_v_s  = below_s & pending_up_r;
  assign here_s      = |(at_s & any_s);
  assign beyond_up_s = |(above_s & any_s);
  assign beyond_dn_s = |(below_s & any_s);
  assign beyond_dir_s = dir_up_r ? beyond_up_s : beyond_dn_s;

  // Re-target only to a call that the cabin passes before reaching its target.
  assign rt_up_v_s   = near_up_v_s & tgt_below_s;
  assign rt_dn_v_s   = near_dn_v_s & tgt_above_s;
  assign retgt_s     = cur_ok_s & (dir_up_r ? (|rt_up_v_s) : (|rt_dn_v_s));
  assign retgt_idx_s = dir_up_r ? low_idx(rt_up_v_s) : high_idx(rt_dn_v_s);

  assign serve_s   = (state_r == ST_SERVE);
  assign clr_cab_s = at_s;
  assign clr_up_s  = at_s & {FLOOR_COUNT{dir_up_r | ~beyond_dir_s}};
  assign clr_dn_s  = at_s & {FLOOR_COUNT{~dir_up_r | ~beyond_dir_s}};

  // Target choice: nearest same-way call ahead, farthest opposite call ahead, here, then reverse.
  always_comb begin
    cand_s     = 1'b0;
    cand_rev_s = 1'b0;
    cand_idx_s = cur_floor;
    if (!cur_ok_s) begin
      cand_s = 1'b0;
    end else if (dir_up_r) begin
      if (|near_up_v_s) begin
        cand_s = 1'b1; cand_idx_s = low_idx(near_up_v_s);
      end else if (|far_up_v_s) begin
        cand_s = 1'b1; cand_idx_s = high_idx(far_up_v_s);
      end else if (here_s) begin
        cand_s = 1'b1; cand_idx_s = cur_floor;
      end else if (|near_dn_v_s) begin
        cand_s = 1'b1; cand_rev_s = 1'b1; cand_idx_s = high_idx(near_dn_v_s);
      end else if (|far_dn_v_s) begin
        cand_s = 1'b1; cand_rev_s = 1'b1; cand_idx_s = low_idx(far_dn_v_s);
      end else begin
        cand_s = 1'b0;
      end
    end else begin
      if (|near_dn_v_s) begin
        cand_s = 1'b1; cand_idx_s = high_idx(near_dn_v_s);
      end else if (|far_dn_v_s) begin
        cand_s = 1'b1; cand_idx_s = low_idx(far_dn_v_s);
      end else if (here_s) begin
        cand_s = 1'b1; cand_idx_s = cur_floor;
      end else if (|near_up_v_s) begin
        cand_s = 1'b1; cand_rev_s = 1'b1; cand_idx_s = low_idx(near_up_v_s);
      end else if (|far_up_v_s) begin
        cand_s = 1'b1; cand_rev_s = 1'b1; cand_idx_s = high_idx(far_up_v_s);
      end else begin
        cand_s = 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|any_s) state_nxt_s = ST_SELECT;
        else        state_nxt_s = ST_IDLE;
      end
      ST_SELECT: begin
        if (cand_s) state_nxt_s = ST_ISSUE;
        else        state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (target_ready) state_nxt_s = ST_MOVING;
        else              state_nxt_s = ST_ISSUE;
      end
      ST_MOVING: begin
        if (arrived)      state_nxt_s = ST_SERVE;
        else if (retgt_s) state_nxt_s = ST_ISSUE;
        else              state_nxt_s = ST_MOVING;
      end
      ST_SERVE: state_nxt_s = ST_SELECT;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Call latches, registered outputs, target and direction updates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_up_r   <= {FLOOR_COUNT{1'b0}};
      pending_dn_r   <= {FLOOR_COUNT{1'b0}};
      pending_cab_r  <= {FLOOR_COUNT{1'b0}};
      target_valid_r <= 1'b0;
      target_floor_r <= {FLOOR_W{1'b0}};
      dir_up_r       <= 1'b1;
      busy_r         <= 1'b0;
    end else begin
      // New presses are OR-ed in after the clear so a press always wins.
      pending_up_r   <= (pending_up_r  & ~(clr_up_s  & {FLOOR_COUNT{serve_s}})) | hall_up_req;
      pending_dn_r   <= (pending_dn_r  & ~(clr_dn_s  & {FLOOR_COUNT{serve_s}})) | hall_dn_req;
      pending_cab_r  <= (pending_cab_r & ~(clr_cab_s & {FLOOR_COUNT{serve_s}})) | cabin_req;
      target_valid_r <= (state_nxt_s == ST_ISSUE);
      busy_r         <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_SELECT: begin
          if (cand_s) target_floor_r <= cand_idx_s;
          if (cand_s && cand_rev_s) dir_up_r <= ~dir_up_r;
        end
        ST_MOVING: begin
          if (!arrived && retgt_s) target_floor_r <= retgt_idx_s;
        end
        ST_SERVE: begin
          if (!beyond_dir_s) dir_up_r <= ~dir_up_r;
        end
        default: begin
        end
      endcase
    end
  end

  assign target_valid = target_valid_r;
  assign target_floor = target_floor_r;
  assign dir_up       = dir_up_r;
  assign busy         = busy_r;
  assign pending_up   = pending_up_r;
  assign pending_dn   = pending_dn_r;
  assign pending_cab  = pending_cab_r;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: acts as the motion controller and checks
// every issued target against a floor-by-floor model of the call rules.
module tb_elevator_call_scheduler;
  localparam int N = 10;
  localparam int W = 4;

  logic         clock, reset;
  logic [N-1:0] hall_up_req, hall_dn_req, cabin_req;
  logic [W-1:0] cur_floor;
  logic         arrived, target_ready;
  logic         target_valid, dir_up, busy;
  logic [W-1:0] target_floor;
  logic [N-1:0] pending_up, pending_dn, pending_cab;

  int total = 0;
  int bad   = 0;

  bit m_up[N], m_dn[N], m_cab[N];
  bit m_dir;
  int cur;
  int retgt_floor, last_tgt;
  bit last_dir;

  elevator_call_scheduler #(.FLOOR_COUNT(N), .FLOOR_W(W)) dut (
    .clock(clock), .reset(reset),
    .hall_up_req(hall_up_req), .hall_dn_req(hall_dn_req), .cabin_req(cabin_req),
    .cur_floor(cur_floor), .arrived(arrived), .target_ready(target_ready),
    .target_valid(target_valid), .target_floor(target_floor), .dir_up(dir_up), .busy(busy),
    .pending_up(pending_up), .pending_dn(pending_dn), .pending_cab(pending_cab)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit qual(input int f, input bit d);
    return d ? (m_cab[f] | m_up[f]) : (m_cab[f] | m_dn[f]);
  endfunction

  function automatic bit opp(input int f, input bit d);
    return d ? m_dn[f] : m_up[f];
  endfunction

  function automatic bit anyreq(input int f);
    return m_cab[f] | m_up[f] | m_dn[f];
  endfunction

  function automatic bit model_empty();
    for (int f = 0; f < N; f++) if (anyreq(f)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] vec(input int kind);
    logic [N-1:0] v;
    v = '0;
    for (int f = 0; f < N; f++) v[f] = (kind == 1) ? m_up[f] : (kind == 2) ? m_dn[f] : m_cab[f];
    return v;
  endfunction

  function automatic void pick(input int c, input bit d, output int tgt, output bit nd, output bit ok);
    ok = 1'b0; tgt = c; nd = d;
    if (c >= N) return;
    for (int pass = 0; pass < 2; pass++) begin
      bit dd;
      int s;
      dd = (pass == 0) ? d : !d;
      s  = dd ? 1 : -1;
      for (int f = c + s; f >= 0 && f < N; f += s)
        if (!ok && qual(f, dd)) begin ok = 1'b1; tgt = f; nd = dd; end
      for (int f = dd ? N - 1 : 0; f != c; f -= s)
        if (!ok && opp(f, dd)) begin ok = 1'b1; tgt = f; nd = dd; end
      if (!ok && pass == 0 && anyreq(c)) begin ok = 1'b1; tgt = c; nd = d; end
    end
  endfunction

  function automatic void retarget(input int c, input int t, input bit d, output int nt, output bit found);
    int s;
    found = 1'b0; nt = t;
    if (c == t || c >= N) return;
    s = d ? 1 : -1;
    for (int f = c + s; f != t && f >= 0 && f < N; f += s)
      if (!found && qual(f, d)) begin found = 1'b1; nt = f; end
  endfunction

  function automatic void serve_model(input int t);
    int s;
    bit beyond;
    s = m_dir ? 1 : -1;
    m_cab[t] = 1'b0;
    if (m_dir) m_up[t] = 1'b0; else m_dn[t] = 1'b0;
    beyond = 1'b0;
    for (int f = t + s; f >= 0 && f < N; f += s) beyond |= anyreq(f);
    if (!beyond) begin
      if (m_dir) m_dn[t] = 1'b0; else m_up[t] = 1'b0;
      m_dir = !m_dir;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input logic [N-1:0] u, input logic [N-1:0] d, input logic [N-1:0] c);
    hall_up_req = u; hall_dn_req = d; cabin_req = c;
    for (int f = 0; f < N; f++) begin
      if (u[f]) m_up[f] = 1'b1;
      if (d[f]) m_dn[f] = 1'b1;
      if (c[f]) m_cab[f] = 1'b1;
    end
    cyc();
    hall_up_req = '0; hall_dn_req = '0; cabin_req = '0;
  endtask

  task automatic inject(input int f, input int kind);
    logic [N-1:0] m;
    m = '0;
    m[f] = 1'b1;
    case (kind)
      1:       pulse(m, '0, '0);
      2:       pulse('0, m, '0);
      default: pulse('0, '0, m);
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hall_up_req = '0; hall_dn_req = '0; cabin_req = '0;
    arrived = 1'b0; target_ready = 1'b0;
    cyc(); cyc();
    for (int f = 0; f < N; f++) begin m_up[f] = 1'b0; m_dn[f] = 1'b0; m_cab[f] = 1'b0; end
    m_dir = 1'b1;
    reset = 1'b0;
    cyc();
  endtask

  task automatic handshake(input int t);
    int hold;
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      cyc();
      check("hold_valid", target_valid, 1);
      check("hold_floor", target_floor, t);
    end
    target_ready = 1'b1;
    cyc();
    target_ready = 1'b0;
    check("accept_valid_drop", target_valid, 0);
    check("accept_busy", busy, 1);
  endtask

  // One complete trip: issue, accept, travel (with optional calls), arrive, serve.
  task automatic run_trip(input bit rnd, input int inj_floor, input int inj_kind, input logic [N-1:0] serve_cab);
    int  tgt, nt, n;
    bit  nd, ok, found, first;
    retgt_floor = -1;
    pick(cur, m_dir, tgt, nd, ok);
    if (!ok) begin
      repeat (4) cyc();
      check("no_target_valid", target_valid, 0);
      return;
    end
    n = 0;
    while (target_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    check("issue_seen", target_valid, 1);
    if (target_valid !== 1'b1) return;
    m_dir = nd;
    last_tgt = target_floor;
    last_dir = dir_up;
    check("issue_floor", target_floor, tgt);
    check("issue_dir", dir_up, m_dir);
    handshake(tgt);
    first = 1'b1;
    while (cur != tgt) begin
      cur += (tgt > cur) ? 1 : -1;
      cur_floor = W'(cur);
      if (first && inj_kind != 0) inject(inj_floor, inj_kind);
      else if (rnd && $urandom_range(0, 2) == 0) inject($urandom_range(0, N - 1), $urandom_range(1, 3));
      else cyc();
      first = 1'b0;
      cyc(); cyc();
      retarget(cur, tgt, m_dir, nt, found);
      check("retarget_valid", target_valid, found);
      if (found && target_valid === 1'b1) begin
        tgt = nt;
        retgt_floor = nt;
        check("retarget_floor", target_floor, tgt);
        handshake(tgt);
      end
    end
    arrived = 1'b1;
    cyc();
    arrived = 1'b0;
    serve_model(tgt);
    cabin_req = serve_cab;
    for (int f = 0; f < N; f++) if (serve_cab[f]) m_cab[f] = 1'b1;
    cyc();
    cabin_req = '0;
    check("serve_pending_up", pending_up, vec(1));
    check("serve_pending_dn", pending_dn, vec(2));
    check("serve_pending_cab", pending_cab, vec(3));
  endtask

  initial begin
    bit ever_tv;
    int n;
    reset = 1'b1;
    hall_up_req = '0; hall_dn_req = '0; cabin_req = '0;
    cur = 0; cur_floor = '0; arrived = 1'b0; target_ready = 1'b0;
    cyc();
    check("rst_valid", target_valid, 0);
    check("rst_floor", target_floor, 0);
    check("rst_dir", dir_up, 1);
    check("rst_busy", busy, 0);
    check("rst_pending", {pending_up, pending_dn, pending_cab}, 0);

    // Single cabin call from floor 0.
    do_reset();
    cur = 0; cur_floor = W'(cur);
    pulse('0, '0, 10'b00_0010_0000);
    run_trip(1'b0, 0, 0, '0);
    check("req030_target", last_tgt, 5);
    repeat (3) cyc();
    check("req030_busy", busy, 0);
    check("req030_cab5", pending_cab[5], 0);

    // Hall up call inside the travel window re-targets; hall down does not.
    do_reset();
    cur = 2; cur_floor = W'(cur);
    pulse('0, '0, 10'b01_0000_0000);
    run_trip(1'b0, 5, 1, '0);
    check("req031_up_retarget", retgt_floor, 5);
    do_reset();
    cur = 2; cur_floor = W'(cur);
    pulse('0, '0, 10'b01_0000_0000);
    run_trip(1'b0, 5, 2, '0);
    check("req031_dn_no_retarget", retgt_floor, -1);
    check("req031_dn_target", last_tgt, 8);

    // Up sweep first, then reversal.
    do_reset();
    cur = 4; cur_floor = W'(cur);
    pulse(10'b00_1000_0000, 10'b00_0000_0010, '0);
    run_trip(1'b0, 0, 0, '0);
    check("req032_first", last_tgt, 7);
    run_trip(1'b0, 0, 0, '0);
    check("req032_second", last_tgt, 1);
    check("req032_dir", last_dir, 0);

    // A press during the serve cycle survives the clear.
    do_reset();
    cur = 0; cur_floor = W'(cur);
    pulse('0, '0, 10'b00_0100_0000);
    run_trip(1'b0, 0, 0, 10'b00_0100_0000);
    check("req033_cab6", pending_cab[6], 1);
    run_trip(1'b0, 0, 0, '0);

    // Reset while moving and while issuing.
    do_reset();
    cur = 0; cur_floor = W'(cur);
    pulse(10'b00_1000_0000, '0, 10'b00_0010_0100);
    n = 0;
    while (target_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    check("req034_issue", target_valid, 1);
    target_ready = 1'b1; cyc(); target_ready = 1'b0;
    check("req034_moving_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("req034_valid", target_valid, 0);
    check("req034_busy", busy, 0);
    check("req034_floor", target_floor, 0);
    check("req034_dir", dir_up, 1);
    check("req034_pending", {pending_up, pending_dn, pending_cab}, 0);
    cyc();
    reset = 1'b0;
    for (int f = 0; f < N; f++) begin m_up[f] = 1'b0; m_dn[f] = 1'b0; m_cab[f] = 1'b0; end
    m_dir = 1'b1;
    ever_tv = 1'b0;
    repeat (10) begin cyc(); ever_tv |= target_valid; end
    check("req034_quiet", ever_tv, 0);
    check("req034_idle", busy, 0);
    pulse('0, '0, 10'b00_0001_0000);
    n = 0;
    while (target_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    check("issue_reset_seen", target_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("issue_reset_valid", target_valid, 0);
    cyc();
    reset = 1'b0;
    for (int f = 0; f < N; f++) begin m_up[f] = 1'b0; m_dn[f] = 1'b0; m_cab[f] = 1'b0; end
    m_dir = 1'b1;
    cyc();

    // Out-of-range cabin position yields no target until it becomes valid.
    do_reset();
    cur = 12; cur_floor = W'(cur);
    pulse('0, '0, 10'b00_0000_1000);
    ever_tv = 1'b0;
    repeat (12) begin cyc(); ever_tv |= target_valid; end
    check("req035_no_valid", ever_tv, 0);
    check("req035_latched", pending_cab[3], 1);
    cur = 0; cur_floor = W'(cur);
    run_trip(1'b0, 0, 0, '0);
    check("req035_target", last_tgt, 3);

    // Randomized trips.
    for (int trip = 0; trip < 40; trip++) begin
      if (model_empty()) begin
        repeat (3) cyc();
        check("rand_idle_busy", busy, 0);
        check("rand_idle_valid", target_valid, 0);
        inject($urandom_range(0, N - 1), $urandom_range(1, 3));
      end
      run_trip(1'b1, 0, 0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
